// File: rtl/mult_seq_ctrl_pkg.sv
// Shared definitions for the sequential shift-add multiplier controller:
// FSM state encoding and iteration counter sizing.
package mult_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ABS_A  = 3'd1,
        ABS_B  = 3'd2,
        CALC   = 3'd3,
        FIX_LO = 3'd4,
        FIX_HI = 3'd5,
        DONE   = 3'd6
    } state_t;

    // Width of a counter able to count up to (and hold) width iterations.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_seq_ctrl_fa_nbit.sv
// Ripple-carry adder shared by every arithmetic step of the multiplier.
// Index 0 is the MSB; the carry ripples from index WIDTH-1 up to index 0.
module fa_nbit #(
    parameter int WIDTH = 32
) (
    input  logic [0:WIDTH-1] a,
    input  logic [0:WIDTH-1] b,
    input  logic             cin,
    output logic [0:WIDTH-1] sum,
    output logic             cout
);

    logic [0:WIDTH] carry;

    assign carry[WIDTH] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ carry[i+1];
        assign carry[i] = (a[i] & b[i]) | (a[i] & carry[i+1]) | (b[i] & carry[i+1]);
    end

    assign cout = carry[0];

endmodule

// File: rtl/mult_seq_ctrl.sv
// Multi-cycle signed/unsigned multiplier: magnitude conversion, shift-add
// accumulation and final negation all time-share a single fa_nbit adder.
module mult_seq_ctrl
    import mult_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic                 signed_op,
    input  logic [0:WIDTH-1]     A,
    input  logic [0:WIDTH-1]     B,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [0:2*WIDTH-1]   P,
    output logic                 busy
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t state_q, state_d;

    logic [0:WIDTH-1] a_q, b_q, m_q, hi_q, lo_q;
    logic             sop_q, c_q;
    logic [CNT_W-1:0] cnt_q;

    logic [0:WIDTH-1] add_a, add_b, sum;
    logic             add_cin, cout;
    logic             na, nb, np;

    // Sign flags derive from the captured operands, so they stay valid for the whole operation.
    assign na = sop_q & a_q[0];
    assign nb = sop_q & b_q[0];
    assign np = na ^ nb;

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);

    fa_nbit #(.WIDTH(WIDTH)) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_valid) state_d = ABS_A;
            ABS_A:   state_d = ABS_B;
            ABS_B:   state_d = CALC;
            CALC:    if (cnt_q == LAST_ITER) state_d = FIX_LO;
            FIX_LO:  state_d = FIX_HI;
            FIX_HI:  state_d = DONE;
            DONE:    if (result_valid && result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Conditional inversion plus carry-in gives two's-complement negation for free.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state_q)
            ABS_A: begin
                add_a   = na ? ~a_q : a_q;
                add_cin = na;
            end
            ABS_B: begin
                add_a   = nb ? ~b_q : b_q;
                add_cin = nb;
            end
            CALC: begin
                add_a = hi_q;
                add_b = lo_q[WIDTH-1] ? m_q : '0;
            end
            FIX_LO: begin
                add_a   = np ? ~lo_q : lo_q;
                add_cin = np;
            end
            FIX_HI: begin
                add_a   = np ? ~hi_q : hi_q;
                add_cin = c_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q          <= '0;
            b_q          <= '0;
            m_q          <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            sop_q        <= 1'b0;
            c_q          <= 1'b0;
            cnt_q        <= '0;
            P            <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        a_q   <= A;
                        b_q   <= B;
                        sop_q <= signed_op;
                    end
                end
                ABS_A: m_q <= sum;
                ABS_B: begin
                    lo_q  <= sum;
                    hi_q  <= '0;
                    cnt_q <= '0;
                end
                CALC: begin
                    hi_q  <= {cout, sum[0:WIDTH-2]};
                    lo_q  <= {sum[WIDTH-1], lo_q[0:WIDTH-2]};
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                FIX_LO: begin
                    lo_q <= sum;
                    c_q  <= cout;
                end
                FIX_HI: hi_q <= sum;
                DONE: begin
                    // First DONE cycle publishes the product; it then holds until accepted.
                    if (!result_valid) begin
                        P            <= {hi_q, lo_q};
                        result_valid <= 1'b1;
                    end else if (result_ready) begin
                        result_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed self-checking bench for mult_seq_ctrl: latency, signed/unsigned
// products, backpressure, mid-operation reset and back-to-back requests.
module tb_mult_seq_ctrl;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 5;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start_valid = 1'b0;
    logic                 signed_op = 1'b0;
    logic                 result_ready = 1'b1;
    logic [0:WIDTH-1]     A = '0;
    logic [0:WIDTH-1]     B = '0;
    logic                 start_ready;
    logic                 result_valid;
    logic                 busy;
    logic [0:2*WIDTH-1]   P;

    int total = 0;
    int bad   = 0;

    mult_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .signed_op    (signed_op),
        .A            (A),
        .B            (B),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .P            (P),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Presents a request at #1 after an edge while the DUT is idle; the next edge is cycle 0.
    task automatic start_op(input logic [0:WIDTH-1] a, input logic [0:WIDTH-1] b, input logic sgn);
        A           = a;
        B           = b;
        signed_op   = sgn;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
    endtask

    // Counts cycles after the accept edge until result_valid; lat stays -1 on timeout.
    task automatic run_to_valid(output int lat, output logic busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (result_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        total++; if (start_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_start_ready: got %b want 1", start_ready); end
        total++; if (result_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_result_valid: got %b want 0", result_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        total++; if (P !== 64'h0) begin bad++; $display("[TB] FAIL reset_P: got %h want 0", P); end
    endtask

    task automatic test_single_op(input logic [0:WIDTH-1] a, input logic [0:WIDTH-1] b,
                                  input logic sgn, input logic [0:2*WIDTH-1] exp, input string name);
        int   lat;
        logic busy_ok;
        result_ready = 1'b1;
        start_op(a, b, sgn);
        run_to_valid(lat, busy_ok);
        total++; if (lat != LAT) begin bad++; $display("[TB] FAIL %s_latency: got %0d want %0d", name, lat, LAT); end
        total++; if (P !== exp) begin bad++; $display("[TB] FAIL %s_P: got %h want %h", name, P, exp); end
        total++; if (busy_ok !== 1'b1) begin bad++; $display("[TB] FAIL %s_busy: got %b want 1", name, busy_ok); end
        @(posedge clk);
        #1;
        total++; if (result_valid !== 1'b0) begin bad++; $display("[TB] FAIL %s_valid_drop: got %b want 0", name, result_valid); end
        total++; if (start_ready !== 1'b1) begin bad++; $display("[TB] FAIL %s_ready_back: got %b want 1", name, start_ready); end
    endtask

    task automatic test_backpressure();
        int   lat;
        logic busy_ok;
        logic [0:2*WIDTH-1] held;
        result_ready = 1'b0;
        start_op(32'h0000_1234, 32'h0000_0010, 1'b0);
        run_to_valid(lat, busy_ok);
        total++; if (lat != LAT) begin bad++; $display("[TB] FAIL bp_latency: got %0d want %0d", lat, LAT); end
        total++; if (P !== 64'h0000_0000_0001_2340) begin bad++; $display("[TB] FAIL bp_P: got %h want %h", P, 64'h0000_0000_0001_2340); end
        held = 64'h0000_0000_0001_2340;
        for (int i = 0; i < 10; i++) begin
            A           = 32'h0000_0100 + i;
            B           = 32'h0000_0003;
            signed_op   = i[0];
            start_valid = 1'b1;
            @(posedge clk);
            #1;
            total++; if (P !== held) begin bad++; $display("[TB] FAIL bp_hold_P[%0d]: got %h want %h", i, P, held); end
            total++; if (start_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_start_ready[%0d]: got %b want 0", i, start_ready); end
            total++; if (result_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid[%0d]: got %b want 1", i, result_valid); end
        end
        start_valid  = 1'b0;
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        total++; if (result_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_release_valid: got %b want 0", result_valid); end
        total++; if (start_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_ready: got %b want 1", start_ready); end
        @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL bp_not_queued: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid_calc();
        int   lat;
        logic busy_ok;
        result_ready = 1'b1;
        start_op(32'd7, 32'd9, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++; if (start_ready !== 1'b1) begin bad++; $display("[TB] FAIL midrst_start_ready: got %b want 1", start_ready); end
        total++; if (result_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_valid: got %b want 0", result_valid); end
        total++; if (P !== 64'h0) begin bad++; $display("[TB] FAIL midrst_P: got %h want 0", P); end
        start_op(32'd6, 32'd7, 1'b0);
        run_to_valid(lat, busy_ok);
        total++; if (lat != LAT) begin bad++; $display("[TB] FAIL midrst_new_latency: got %0d want %0d", lat, LAT); end
        total++; if (P !== 64'd42) begin bad++; $display("[TB] FAIL midrst_new_P: got %h want %h", P, 64'd42); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int   lat;
        logic busy_ok;
        result_ready = 1'b1;
        start_op(32'h0001_0000, 32'h0001_0000, 1'b0);
        run_to_valid(lat, busy_ok);
        total++; if (lat != LAT) begin bad++; $display("[TB] FAIL b2b_first_latency: got %0d want %0d", lat, LAT); end
        total++; if (P !== 64'h0000_0001_0000_0000) begin bad++; $display("[TB] FAIL b2b_first_P: got %h want %h", P, 64'h0000_0001_0000_0000); end
        A           = 32'hFFFF_FFFF;
        B           = 32'hFFFF_FFFF;
        signed_op   = 1'b1;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        total++; if (start_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready_after_hs: got %b want 1", start_ready); end
        total++; if (result_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_valid_after_hs: got %b want 0", result_valid); end
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_second_accepted: got busy=%b want 1", busy); end
        run_to_valid(lat, busy_ok);
        total++; if (lat != LAT) begin bad++; $display("[TB] FAIL b2b_second_latency: got %0d want %0d", lat, LAT); end
        total++; if (P !== 64'h0000_0000_0000_0001) begin bad++; $display("[TB] FAIL b2b_second_P: got %h want %h", P, 64'h1); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        $display("[TB] starting mult_seq_ctrl bench");
        test_reset();
        test_single_op(32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, "u_3x5");
        test_single_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "u_max");
        test_single_op(32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, "s_m3x5");
        test_single_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "s_minneg");
        test_single_op(32'h8000_0000, 32'd2, 1'b0, 64'h0000_0001_0000_0000, "u_top_bit");
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Sequential shift-add multiplier controller that time-shares one WIDTH-bit ripple-carry adder (fa_nbit) across every arithmetic step of a multiply.
- Steps: operand absolute value, partial-product accumulation, and final 2*WIDTH-bit negation.
- Serves as the multi-cycle MUL unit beside the execute stage, with valid/ready handshakes on both sides.
- Bit ordering matches the datapath: index 0 is MSB, index WIDTH-1 is LSB.

Parameters:
- WIDTH, 32, operand width; product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start_valid  input  1  request carries valid operands.
- start_ready  output  1  controller can accept a request; high only in IDLE.
- signed_op  input  1  1 means two's-complement operands; 0 means unsigned.
- A  input  [0:WIDTH-1]  multiplicand.
- B  input  [0:WIDTH-1]  multiplier.
- result_valid  output  1  P holds a finished product.
- result_ready  input  1  consumer accepts P.
- P  output  [0:2*WIDTH-1]  product; P[0:WIDTH-1] is the high half.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- On rst:
  - state becomes IDLE.
  - result_valid=0, P=0, busy=0.
  - start_ready=1 in the first cycle after reset.
  - All internal registers are cleared.
- Reset during any state abandons the operation with no output.
- States: IDLE -> ABS_A -> ABS_B -> CALC (WIDTH cycles) -> FIX_LO -> FIX_HI -> DONE -> IDLE.
- Fixed latency:
  - Accept edge is cycle 0.
  - result_valid rises at cycle WIDTH+5 (37 for WIDTH=32).
  - Latency is the same for signed and unsigned operations.
- IDLE:
  - Accepts a request when start_valid && start_ready.
  - Registers A, B, signed_op, and the sign flags: nA=signed_op&A[0], nB=signed_op&B[0], nP=nA^nB.
  - start_valid in any other state is ignored; it is not queued.
- ABS_A: adder inputs are (nA ? ~A : A), 0, with cin=nA. The sum replaces the multiplicand register M.
- ABS_B: same as ABS_A using B and nB. The sum loads the low accumulator LO. HI is set to 0.
- CALC, one iteration per cycle:
  - Adder inputs are HI, (LO[WIDTH-1] ? M : 0), with cin=0.
  - {HI,LO} <= {cout, sum, LO[0:WIDTH-2]}, a logical right shift by one that brings the carry in at the top.
  - A WIDTH-wide iteration counter exits CALC after exactly WIDTH iterations.
- FIX_LO: adder inputs are (nP ? ~LO : LO), 0, with cin=nP. LO <= sum, and the carry register c <= cout.
- FIX_HI: adder inputs are (nP ? ~HI : HI), 0, with cin=c. HI <= sum.
- DONE:
  - P = {HI,LO} is registered. result_valid=1.
  - P stays stable while result_ready=0.
  - On result_valid && result_ready, go to IDLE. result_valid drops the next cycle; start_ready rises the next cycle.
  - There is no same-cycle restart.
- Exactly one adder instance exists. All adder inputs and cin are muxed by state. In IDLE and DONE the adder inputs are 0 and its output is unused.
- Most-negative operand: its magnitude 2^(WIDTH-1) is handled correctly as unsigned, with no overflow special case.
- Unsigned operation: nA, nB and nP are all 0, so the ABS and FIX states pass values through unchanged.

Decomposition:
- Header mult_defs.vh holds:
  - state encodings: IDLE, ABS_A, ABS_B, CALC, FIX_LO, FIX_HI, DONE, 3-bit.
  - the counter width constant.
- The sub-module is the existing fa_nbit, instantiated once with WIDTH passed through.
- FSM, operand muxes, shift registers and counter live in mult_seq_ctrl.

Test Plan:
- Unsigned: A=3, B=5 -> P=0x000000000000000F with result_valid at cycle 37; busy=1 for cycles 1-37.
- Unsigned: A=B=0xFFFFFFFF -> P=0xFFFFFFFE00000001.
- Signed: A=0xFFFFFFFD (-3), B=5 -> P=0xFFFFFFFFFFFFFFF1. Signed: A=B=0x80000000 -> P=0x4000000000000000.
- Backpressure:
  - Stimulus: result_ready=0 for 10 cycles after result_valid, while start_valid pulses with new operands.
  - Required: P stays stable, start_ready stays 0, and the new request is ignored.
  - Then result_ready=1 for one cycle -> IDLE, and start_ready=1 the next cycle.
- Reset mid-CALC:
  - Stimulus: rst at cycle 10 of the A=7, B=9 operation.
  - Required: the next cycle shows start_ready=1, result_valid=0, P=0.
  - A new operation A=6, B=7 then yields P=42 at its cycle 37.
- Back-to-back: two operations with result_ready held at 1 -> the second is accepted on the cycle after the first handshake, and both results are correct.
